// File: rtl/adc_avg_filter.sv
// Boxcar moving-average filter: keeps the last 2^LOG2_N ADC samples and emits the truncated mean.
// Optional macro AVG_DECIMATE_EN: emit only every Nth mean (non-overlapping windows).
module adc_avg_filter #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_stb,
  input  logic              flush,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              filled
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned SUM_W = DATA_W + LOG2_N;

  typedef enum logic [0:0] {StFill, StRun} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   win_q [N];
  logic [LOG2_N-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LOG2_N-1:0]   fill_cnt_q, fill_cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   avg_q, avg_d;
  logic                valid_q, valid_d;
  logic                filled_q, filled_d;
  logic                accept, fill_last, run_emit, emit;

  assign accept    = sample_stb & ~flush;
  assign fill_last = (fill_cnt_q == LOG2_N'(N - 1));

`ifdef AVG_DECIMATE_EN
  logic [LOG2_N-1:0] decim_q, decim_d;

  // Counter is 0 on entering RUN, so the Nth accepted sample after the first mean emits.
  assign run_emit = (decim_q == LOG2_N'(N - 1));

  always_comb begin
    decim_d = decim_q;
    if (flush) begin
      decim_d = '0;
    end else if (accept && state_q == StRun) begin
      decim_d = decim_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_q <= '0;
    end else begin
      decim_q <= decim_d;
    end
  end
`else
  assign run_emit = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StFill;
    end else if (accept && state_q == StFill && fill_last) begin
      state_d = StRun;
    end
  end

  // Window datapath: the slot being overwritten is 0 while filling, so one equation suffices.
  always_comb begin
    sum_d      = sum_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    filled_d   = filled_q;
    if (flush) begin
      sum_d      = '0;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      filled_d   = 1'b0;
    end else if (accept) begin
      sum_d    = sum_q + SUM_W'(sample_in) - SUM_W'(win_q[wr_ptr_q]);
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (state_q == StFill) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_last) begin
          filled_d = 1'b1;
        end
      end
    end
  end

  // Output logic
  always_comb begin
    emit    = accept && ((state_q == StFill && fill_last) || (state_q == StRun && run_emit));
    avg_d   = avg_q;
    valid_d = 1'b0;
    if (emit) begin
      avg_d   = DATA_W'(sum_d >> LOG2_N);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        win_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      sum_q      <= '0;
      avg_q      <= '0;
      valid_q    <= 1'b0;
      filled_q   <= 1'b0;
    end else begin
      if (flush) begin
        for (int i = 0; i < int'(N); i++) begin
          win_q[i] <= '0;
        end
      end else if (accept) begin
        win_q[wr_ptr_q] <= sample_in;
      end
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      sum_q      <= sum_d;
      avg_q      <= avg_d;
      valid_q    <= valid_d;
      filled_q   <= filled_d;
    end
  end

  assign avg_out   = avg_q;
  assign avg_valid = valid_q;
  assign filled    = filled_q;

endmodule
